digit_scan_ctrl: RTL

Time-multiplexing controller for the dual common-anode 7-segment display. Sits directly upstream of the segment decoder. Each cycle it chooses which 4-bit operand (s1 or s2) is presented to the decoder and which anode is driven. Blanking gaps between digits prevent ghosting, and operands are sampled only at gap entry, so the decoder input never changes while an anode is on.

---
 rtl/digit_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Dual-digit 7-segment scan controller: alternates two anodes with blanking gaps and
// samples each operand only when entering the gap that precedes its digit.
module digit_scan_ctrl #(
  parameter int unsigned ON_CYCLES    = 24000,
  parameter int unsigned BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] digit,
  output logic       blank,
  output logic       anode1,
  output logic       anode2,
  output logic       sel,
  output logic       frame_tick
);

  localparam int unsigned MaxCycles = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    StBlankA,
    StShow1,
    StBlankB,
    StShow2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      digit_q, digit_d;
  logic            sel_q, sel_d;
  logic            anode1_q, anode1_d;
  logic            anode2_q, anode2_d;
  logic            blank_q, blank_d;
  logic            frame_tick_q, frame_tick_d;
  logic            phase_last;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    sel_d        = sel_q;
    frame_tick_d = 1'b0;

    if (state_q == StShow1 || state_q == StShow2) begin
      phase_last = (cnt_q == OnLast);
    end else begin
      phase_last = (cnt_q == BlankLast);
    end

    if (!en) begin
      // Dark display parks at the start of BLANK_A, tracking s1 so a restart is clean.
      state_d = StBlankA;
      cnt_d   = '0;
      digit_d = s1;
      sel_d   = 1'b0;
    end else if (phase_last) begin
      cnt_d = '0;
      unique case (state_q)
        StBlankA: state_d = StShow1;
        StShow1: begin
          state_d = StBlankB;
          digit_d = s2;
          sel_d   = 1'b1;
        end
        StBlankB: state_d = StShow2;
        StShow2: begin
          state_d      = StBlankA;
          digit_d      = s1;
          sel_d        = 1'b0;
          frame_tick_d = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Anode/blank are registered off the next state so they align with digit.
    anode1_d = (state_d != StShow1);
    anode2_d = (state_d != StShow2);
    blank_d  = anode1_d & anode2_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBlankA;
      cnt_q        <= '0;
      digit_q      <= s1;
      sel_q        <= 1'b0;
      anode1_q     <= 1'b1;
      anode2_q     <= 1'b1;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      sel_q        <= sel_d;
      anode1_q     <= anode1_d;
      anode2_q     <= anode2_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit      = digit_q;
  assign sel        = sel_q;
  assign anode1     = anode1_q;
  assign anode2     = anode2_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

endmodule
